// File: rtl/ahb_cmd_pkg.sv
// Shared types and constants for the AHB-Lite command initiator.
package ahb_cmd_pkg;

    typedef enum logic [1:0] {
        WRITE_KEY  = 2'b00,
        WRITE_DATA = 2'b01,
        READ_DATA  = 2'b10,
        OP_ILLEGAL = 2'b11
    } cmd_op_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR,
        ST_DONE
    } mst_state_t;

    localparam logic [15:0] DEF_KEY_ADDR  = 16'd0;
    localparam logic [15:0] DEF_DATA_ADDR = 16'd32;

    typedef struct packed {
        cmd_op_t      op;
        logic [127:0] wdata;
    } cmd_t;

    function automatic logic op_is_write(input cmd_op_t op);
        return (op == WRITE_KEY) || (op == WRITE_DATA);
    endfunction

endpackage

// File: rtl/ahb_cmd_master_wait_counter.sv
// Bus wait-state counter; flags the last permitted stalled cycle.
module ahb_wait_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic term
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (clr) begin
            cnt <= 8'd0;
        end else if (inc && cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign term = (cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/ahb_cmd_master.sv
// AHB-Lite initiator: one address + one data phase per host command,
// with wait-state, two-cycle error and timeout handling.
module ahb_cmd_master
    import ahb_cmd_pkg::*;
#(
    parameter logic [15:0] KEY_ADDR  = DEF_KEY_ADDR,
    parameter logic [15:0] DATA_ADDR = DEF_DATA_ADDR,
    parameter int          TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [127:0] cmd_wdata,
    output logic         rsp_valid,
    output logic [127:0] rsp_rdata,
    output logic         rsp_error,
    output logic         rsp_timeout,
    output logic [15:0]  HADDR,
    output logic [1:0]   HTRANS,
    output logic         HWRITE,
    output logic [127:0] HWDATA,
    input  logic [127:0] HRDATA,
    input  logic         HREADY,
    input  logic         HRESP
);

    mst_state_t   state, state_d;
    cmd_t         cmd_q;
    logic [127:0] rdata_q;
    logic         err_q, tmo_q;

    logic accept, cap_rdata, set_err, set_tmo;
    logic cnt_clr, cnt_inc, cnt_term;

    ahb_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .term (cnt_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cmd_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state <= state_d;
            if (accept) begin
                cmd_q.op    <= cmd_op_t'(cmd_op);
                cmd_q.wdata <= cmd_wdata;
                rdata_q     <= '0;
                err_q       <= 1'b0;
                tmo_q       <= 1'b0;
            end
            if (cap_rdata) rdata_q <= HRDATA;
            if (set_err)   err_q   <= 1'b1;
            if (set_tmo)   tmo_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        cap_rdata = 1'b0;
        set_err   = 1'b0;
        set_tmo   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cnt_clr = 1'b1;
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_op_t'(cmd_op) == OP_ILLEGAL) begin
                        state_d = ST_DONE;
                        set_err = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d = ST_DATA;
                    cnt_clr = 1'b1;
                end else if (cnt_term) begin
                    state_d = ST_DONE;
                    set_err = 1'b1;
                    set_tmo = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DATA: begin
                cnt_inc = !HREADY;
                // timeout outranks an error response first seen this cycle
                unique case (1'b1)
                    (!HREADY && cnt_term): begin
                        state_d = ST_DONE;
                        set_err = 1'b1;
                        set_tmo = 1'b1;
                    end
                    (!HREADY && !cnt_term && HRESP): begin
                        state_d = ST_ERR;
                    end
                    (HREADY && !HRESP): begin
                        state_d   = ST_DONE;
                        cap_rdata = (cmd_q.op == READ_DATA);
                    end
                    (HREADY && HRESP): begin
                        state_d = ST_DONE;
                        set_err = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_ERR: begin
                if (HREADY) begin
                    state_d = ST_DONE;
                    set_err = 1'b1;
                end else if (cnt_term) begin
                    state_d = ST_DONE;
                    set_err = 1'b1;
                    set_tmo = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready   = 1'b0;
        HTRANS      = HTRANS_IDLE;
        HADDR       = 16'd0;
        HWRITE      = 1'b0;
        HWDATA      = '0;
        rsp_valid   = 1'b0;
        rsp_error   = 1'b0;
        rsp_timeout = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
            end
            ST_ADDR: begin
                HTRANS = HTRANS_NONSEQ;
                HWRITE = op_is_write(cmd_q.op);
                HADDR  = (cmd_q.op == WRITE_KEY) ? KEY_ADDR : DATA_ADDR;
            end
            ST_DATA, ST_ERR: begin
                HWDATA = op_is_write(cmd_q.op) ? cmd_q.wdata : '0;
            end
            ST_DONE: begin
                rsp_valid   = 1'b1;
                rsp_error   = err_q;
                rsp_timeout = tmo_q;
            end
            default: ;
        endcase
    end

    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_ahb_cmd_master.sv
// Randomised scoreboard bench for ahb_cmd_master with a scripted responder.
module tb_ahb_cmd_master;

    localparam int T = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_ready;
    logic [1:0]   cmd_op;
    logic [127:0] cmd_wdata;
    logic         rsp_valid, rsp_error, rsp_timeout;
    logic [127:0] rsp_rdata;
    logic [15:0]  HADDR;
    logic [1:0]   HTRANS;
    logic         HWRITE;
    logic [127:0] HWDATA, HRDATA;
    logic         HREADY, HRESP;

    ahb_cmd_master #(.TIMEOUT(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_error   (rsp_error),
        .rsp_timeout (rsp_timeout),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HWDATA      (HWDATA),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] rdata;
        logic         err;
        logic         tmo;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // response monitor
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1'b1, 1'b0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("rsp_cycle", 128'(cyc), 128'(x.cyc));
                check("rsp_error", rsp_error, x.err);
                check("rsp_timeout", rsp_timeout, x.tmo);
                check("rsp_rdata", rsp_rdata, x.rdata);
            end
        end
    end

    // a: address-phase stalls; d: data-phase stalls before the outcome;
    // mode 0 ok, 1 two-cycle error (plus e extra stalls in ERR), 2 violation
    task automatic run_cmd(input logic [1:0] op, input logic [127:0] wd,
                           input int a, input int d, input int mode,
                           input int e, input logic [127:0] rd);
        logic [1:0] hr[$];
        bit         ph[$];
        exp_t       x;
        int         low, n;
        logic       wr;
        x.rdata = '0;
        x.err   = 1'b0;
        x.tmo   = 1'b0;
        x.cyc   = 0;
        wr = (op != 2'b10);
        if (op == 2'b11) begin
            x.err = 1'b1;
        end else begin
            for (int i = 0; i < a && i < T; i++) begin
                hr.push_back(2'b00);
                ph.push_back(1'b0);
            end
            if (a >= T) begin
                x.err = 1'b1;
                x.tmo = 1'b1;
            end else begin
                hr.push_back(2'b10);
                ph.push_back(1'b0);
                low = d + ((mode == 1) ? 1 + e : 0);
                for (int i = 0; i < low && i < T; i++) begin
                    hr.push_back((mode == 1 && i >= d) ? 2'b01 : 2'b00);
                    ph.push_back(1'b1);
                end
                if (low >= T) begin
                    x.err = 1'b1;
                    x.tmo = 1'b1;
                end else begin
                    hr.push_back((mode == 0) ? 2'b10 : 2'b11);
                    ph.push_back(1'b1);
                    if (mode != 0) x.err = 1'b1;
                    else if (op == 2'b10) x.rdata = rd;
                end
            end
        end

        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_wdata = wd;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            check("accept_wait", cmd_ready, 1'b1);
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_wdata = {4{$urandom}};
        HRDATA    = rd;
        x.cyc = cyc + hr.size();
        sb.push_back(x);

        for (int i = 0; i < hr.size(); i++) begin
            {HREADY, HRESP} = hr[i];
            @(negedge clk);
            if (!ph[i]) begin
                check("addr_htrans", HTRANS, 2'b10);
                check("addr_haddr", HADDR, (op == 2'b00) ? 16'd0 : 16'd32);
                check("addr_hwrite", HWRITE, wr);
                check("addr_ready", cmd_ready, 1'b0);
            end else begin
                check("data_htrans", HTRANS, 2'b00);
                check("data_haddr", HADDR, 16'd0);
                check("data_hwrite", HWRITE, 1'b0);
                check("data_hwdata", HWDATA, wr ? wd : 128'd0);
            end
            @(posedge clk); #1;
        end

        HREADY = 1'($urandom);
        HRESP  = 1'($urandom);
        HRDATA = {4{$urandom}};
        @(negedge clk);
        check("done_htrans", HTRANS, 2'b00);
        check("done_rsp_valid", rsp_valid, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_ready", cmd_ready, 1'b1);
        check("post_rsp_valid", rsp_valid, 1'b0);
        check("post_rdata_hold", rsp_rdata, x.rdata);
    endtask

    initial begin
        logic [127:0] k0, a5;
        k0 = 128'h0123456789ABCDEF0123456789ABCDEF;
        a5 = {16{8'hA5}};
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_wdata = '0;
        HRDATA    = '0;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_htrans", HTRANS, 2'b00);
        check("rst_haddr", HADDR, 16'd0);
        check("rst_hwdata", HWDATA, 128'd0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rdata", rsp_rdata, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_cmd(2'b00, k0, 0, 0, 0, 0, '0);
        run_cmd(2'b10, '0, 0, 3, 0, 0, a5);
        run_cmd(2'b01, {4{32'hDEADBEEF}}, 0, 0, 1, 0, '0);
        run_cmd(2'b10, '0, 0, 20, 0, 0, a5);
        run_cmd(2'b11, k0, 0, 0, 0, 0, '0);
        run_cmd(2'b00, k0, T + 2, 0, 0, 0, '0);
        run_cmd(2'b10, '0, 2, 6, 1, 0, a5);
        run_cmd(2'b01, k0, 1, 7, 0, 0, '0);
        run_cmd(2'b10, '0, 0, 2, 2, 0, a5);

        // reset during a data-phase stall
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        HREADY    = 1'b1;
        @(posedge clk); #1;
        HREADY = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_htrans", HTRANS, 2'b00);
        check("stall_ready", cmd_ready, 1'b0);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_htrans", HTRANS, 2'b00);
        check("midrst_ready", cmd_ready, 1'b1);
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #1;
        rst    = 1'b0;
        HREADY = 1'b1;
        run_cmd(2'b00, k0, 0, 0, 0, 0, '0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            int a, d, m, e;
            op = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 9) == 0) ? T : $urandom_range(0, 3);
            d  = $urandom_range(0, 9);
            m  = $urandom_range(0, 2);
            e  = $urandom_range(0, 3);
            run_cmd(op, {4{$urandom}}, a, d, m, e, {4{$urandom}});
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 128'(sb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

endmodule
